// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port synchronous data memory between the
// CPU MEM stage (load/store) and the write-only camera frame-capture DMA.
// The CPU wins by default; a starvation counter forces the camera in after
// STARVE_MAX consecutive CPU wins, and a burst counter bounds camera ownership.
//
// Handshake: a requester raises *_req with a stable payload and holds both
// until it is served. The CPU is served in every cycle where cpu_req is high
// and cpu_stall is low. The camera is served in every cycle where cam_ack is
// high. At most one requester is served per cycle.
module data_mem_arbiter #(
   parameter  int ADDR_W     = 32,
   parameter  int DATA_W     = 32,
   parameter  int CAM_BURST  = 8,
   parameter  int STARVE_MAX = 4,
   localparam int SW         = $clog2(STARVE_MAX + 1),
   localparam int BW         = $clog2(CAM_BURST + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              cam_req,
   input  logic [ADDR_W-1:0] cam_addr,
   input  logic [DATA_W-1:0] cam_wdata,
   input  logic              cam_last,
   output logic              cam_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              o_dbg_state,
   output logic [SW-1:0]     o_dbg_starve_cnt,
   output logic [BW-1:0]     o_dbg_burst_cnt
);

   typedef enum logic {
      S_CPU = 1'b0,
      S_CAM = 1'b1
   } state_t;

   localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);
   localparam logic [BW-1:0] CAM_BURST_C  = BW'(CAM_BURST);
   // A one-word burst never needs the camera-owned state.
   localparam bit            CAM_SINGLE   = (CAM_BURST == 1);

   state_t          r_state;
   logic [SW-1:0]   r_starve_cnt;
   logic [BW-1:0]   r_burst_cnt;
   logic            r_rvalid;

   logic            w_grant_cpu;
   logic            w_grant_cam;
   logic [BW-1:0]   w_burst_inc;

   // Grant decision: the camera owns the port during a burst, when the CPU is
   // idle, or once the CPU has starved it for STARVE_MAX grants.
   always_comb begin
      w_grant_cam = cam_req && ((r_state == S_CAM) || !cpu_req ||
                                (r_starve_cnt == STARVE_MAX_C));
      w_grant_cpu = cpu_req && !w_grant_cam;
      w_burst_inc = r_burst_cnt + BW'(1);
   end

   // Memory port mux; idle cycles drive zeros so the bus is quiet.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_grant_cpu) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (w_grant_cam) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = cam_addr;
         mem_wdata = cam_wdata;
      end
   end

   // Handshake outputs; load data comes straight from the registered memory
   // output in the cycle after the grant and is zero otherwise.
   always_comb begin
      cpu_stall        = cpu_req && !w_grant_cpu;
      cam_ack          = w_grant_cam;
      cpu_rvalid       = r_rvalid;
      cpu_rdata        = r_rvalid ? mem_rdata : '0;
      o_dbg_state      = r_state;
      o_dbg_starve_cnt = r_starve_cnt;
      o_dbg_burst_cnt  = r_burst_cnt;
   end

   // Ownership FSM with starvation/burst counters and the load-valid flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_CPU;
         r_starve_cnt <= '0;
         r_burst_cnt  <= '0;
         r_rvalid     <= 1'b0;
      end else begin
         r_rvalid <= w_grant_cpu && !cpu_we;

         if (w_grant_cam || !cam_req) begin
            r_starve_cnt <= '0;
         end else if ((r_state == S_CPU) && w_grant_cpu &&
                      (r_starve_cnt != STARVE_MAX_C)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
         end

         case (r_state)
            S_CPU: begin
               if (w_grant_cam) begin
                  if (cam_last || CAM_SINGLE) begin
                     r_burst_cnt <= '0;
                  end else begin
                     r_state     <= S_CAM;
                     r_burst_cnt <= BW'(1);
                  end
               end
            end
            S_CAM: begin
               if (w_grant_cam) begin
                  if (cam_last || (w_burst_inc == CAM_BURST_C)) begin
                     r_state     <= S_CPU;
                     r_burst_cnt <= '0;
                  end else begin
                     r_burst_cnt <= w_burst_inc;
                  end
               end else begin
                  // Camera went idle: hand the port back this same cycle.
                  r_state     <= S_CPU;
                  r_burst_cnt <= '0;
               end
            end
            default: begin
               r_state     <= S_CPU;
               r_burst_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: drives CPU and camera requesters against the arbiter
// with a behavioural single-port memory; expected memory writes and load data
// are queued in arbitration order and compared as the DUT produces them.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cam_req, cam_last, cam_ack;
   logic [31:0] cam_addr, cam_wdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        dbg_state;
   logic [2:0]  dbg_starve;
   logic [3:0]  dbg_burst;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_wr_q[$];
   logic [31:0] exp_rd_q[$];

   logic [31:0] mem [0:1023];

   int          st_tr [64];
   int          bu_tr [64];
   int          sv_tr [64];
   int          stall_tr [64];
   int          cpu_gc [16];
   int          n_cyc;

   always #5 clk = ~clk;

   data_mem_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .cpu_req          (cpu_req),
      .cpu_we           (cpu_we),
      .cpu_addr         (cpu_addr),
      .cpu_wdata        (cpu_wdata),
      .cpu_stall        (cpu_stall),
      .cpu_rvalid       (cpu_rvalid),
      .cpu_rdata        (cpu_rdata),
      .cam_req          (cam_req),
      .cam_addr         (cam_addr),
      .cam_wdata        (cam_wdata),
      .cam_last         (cam_last),
      .cam_ack          (cam_ack),
      .mem_en           (mem_en),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .o_dbg_state      (dbg_state),
      .o_dbg_starve_cnt (dbg_starve),
      .o_dbg_burst_cnt  (dbg_burst)
   );

   // Behavioural single-port memory with 1-cycle registered read data.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
         else        mem_rdata <= mem[mem_addr[9:0]];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every memory write and every load return is matched
   // against the head of its expected queue.
   always @(negedge clk) begin
      if (mem_en && mem_we) begin
         if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(exp_wr_q.size()), 64'd1);
         else check("wr", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
      end
      if (cpu_rvalid) begin
         if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(exp_rd_q.size()), 64'd1);
         else check("rd", 64'(cpu_rdata), 64'(exp_rd_q.pop_front()));
      end
   end

   function automatic logic [31:0] cpu_data(input int i);
      return 32'hC0DE0000 | 32'(i);
   endfunction

   function automatic logic [31:0] cam_data(input logic [31:0] a);
      return 32'hCA000000 | a;
   endfunction

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      cam_req = 1'b0; cam_last = 1'b0; cam_addr = '0; cam_wdata = '0;
   endtask

   task automatic push_cpu_wr(input logic [31:0] base, input int i);
      exp_wr_q.push_back({base + 32'(i), cpu_data(i)});
   endtask

   task automatic push_cam_wr(input logic [31:0] a);
      exp_wr_q.push_back({a, cam_data(a)});
   endtask

   // Both requesters follow the hold-until-served rule; per-cycle state is
   // recorded in traces. Called at posedge+1, returns at posedge+1.
   task automatic run(input int n_cpu, input int cpu_start, input logic [31:0] cpu_base,
                      input int n_cam, input logic [31:0] cam_base, input int last_idx,
                      input int budget);
      int ci  = 0;
      int ki  = 0;
      int cyc = 0;
      while ((ci < n_cpu || ki < n_cam) && cyc < budget) begin
         cpu_req   = (ci < n_cpu) && (cyc >= cpu_start);
         cpu_we    = 1'b1;
         cpu_addr  = cpu_base + 32'(ci);
         cpu_wdata = cpu_data(ci);
         cam_req   = (ki < n_cam);
         cam_addr  = cam_base + 32'(ki);
         cam_wdata = cam_data(cam_base + 32'(ki));
         cam_last  = (ki == last_idx);
         @(negedge clk);
         if (cyc < 64) begin
            st_tr[cyc[5:0]]    = int'(dbg_state);
            bu_tr[cyc[5:0]]    = int'(dbg_burst);
            sv_tr[cyc[5:0]]    = int'(dbg_starve);
            stall_tr[cyc[5:0]] = int'(cpu_stall);
         end
         if (cpu_req && !cpu_stall) begin
            if (ci < 16) cpu_gc[ci[3:0]] = cyc;
            ci++;
         end
         if (cam_ack) ki++;
         cyc++;
         @(posedge clk);
         #1;
      end
      n_cyc = cyc;
      idle_inputs();
      if (ci < n_cpu || ki < n_cam) check("run_timeout", 64'(ci + ki), 64'(n_cpu + n_cam));
   endtask

   function automatic int count_stall(input int from, input int to);
      int c = 0;
      for (int i = from; i <= to; i++) c += stall_tr[i[5:0]];
      return c;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[10'h040] = 32'hDEADBEEF;
      mem_rdata    = '0;
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state",  64'(dbg_state),  64'd0);
      check("rst_rvalid", 64'(cpu_rvalid), 64'd0);
      check("rst_rdata",  64'(cpu_rdata),  64'd0);
      check("rst_ack",    64'(cam_ack),    64'd0);
      check("rst_cnt",    64'({dbg_starve, dbg_burst}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // CPU load from 0x40
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      exp_rd_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      check("ld_stall",  64'(cpu_stall), 64'd0);
      check("ld_mem_en", 64'(mem_en),    64'd1);
      check("ld_mem_we", 64'(mem_we),    64'd0);
      check("ld_addr",   64'(mem_addr),  64'h40);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("ld_rvalid", 64'(cpu_rvalid), 64'd1);
      @(posedge clk); #1;

      // Camera-only 10-word line, cam_last on the 10th word
      for (int i = 0; i < 10; i++) push_cam_wr(32'h100 + 32'(i));
      run(0, 0, 32'h0, 10, 32'h100, 9, 40);
      check("cam10_cycles", 64'(n_cyc),    64'd10);
      check("cam10_st7",    64'(st_tr[7]), 64'd1);
      check("cam10_bu7",    64'(bu_tr[7]), 64'd7);
      check("cam10_st8",    64'(st_tr[8]), 64'd0);
      check("cam10_st9",    64'(st_tr[9]), 64'd1);
      @(negedge clk);
      check("cam10_end",    64'(dbg_state), 64'd0);
      @(posedge clk); #1;

      // Both continuous: 4 CPU, 8 camera, 4 CPU, 8 camera
      for (int i = 0; i < 4; i++)  push_cpu_wr(32'h200, i);
      for (int i = 0; i < 8; i++)  push_cam_wr(32'h300 + 32'(i));
      for (int i = 4; i < 8; i++)  push_cpu_wr(32'h200, i);
      for (int i = 8; i < 16; i++) push_cam_wr(32'h300 + 32'(i));
      run(8, 0, 32'h200, 16, 32'h300, -1, 60);
      check("starve_cycles", 64'(n_cyc),               64'd24);
      check("starve_cnt4",   64'(sv_tr[4]),            64'd4);
      check("starve_cpu3",   64'(cpu_gc[3]),           64'd3);
      check("starve_stall",  64'(count_stall(4, 11)),  64'd8);
      check("starve_cpu4",   64'(cpu_gc[4]),           64'd12);
      check("starve_cpu7",   64'(cpu_gc[7]),           64'd15);
      check("starve_stall2", 64'(count_stall(16, 23)), 64'd0);

      // CPU store arrives during a camera burst ending on cam_last
      for (int i = 0; i < 5; i++) push_cam_wr(32'h400 + 32'(i));
      push_cpu_wr(32'h500, 0);
      run(1, 2, 32'h500, 5, 32'h400, 4, 30);
      check("mid_cpu_cyc", 64'(cpu_gc[0]),          64'd5);
      check("mid_stall",   64'(count_stall(2, 4)),  64'd3);
      check("mid_cycles",  64'(n_cyc),              64'd6);

      // Camera drops its request after 3 words while the CPU waits
      for (int i = 0; i < 3; i++) push_cam_wr(32'h600 + 32'(i));
      push_cpu_wr(32'h700, 0);
      push_cpu_wr(32'h700, 1);
      run(2, 1, 32'h700, 3, 32'h600, -1, 30);
      check("drop_cpu_cyc", 64'(cpu_gc[0]), 64'd3);
      check("drop_st3",     64'(st_tr[3]),  64'd1);
      check("drop_bu3",     64'(bu_tr[3]),  64'd3);
      check("drop_bu4",     64'(bu_tr[4]),  64'd0);
      check("drop_st4",     64'(st_tr[4]),  64'd0);

      // Reset during a burst, in the cycle a CPU load is granted
      cam_req = 1'b1; cam_addr = 32'h800; cam_wdata = cam_data(32'h800);
      push_cam_wr(32'h800);
      @(posedge clk); #1;
      cam_addr = 32'h801; cam_wdata = cam_data(32'h801);
      push_cam_wr(32'h801);
      @(negedge clk);
      check("rstb_incam", 64'(dbg_state), 64'd1);
      @(posedge clk); #1;
      idle_inputs();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      reset = 1'b1;
      @(negedge clk);
      check("rstb_grant", 64'(cpu_stall), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      check("rstb_state",  64'(dbg_state),  64'd0);
      check("rstb_rvalid", 64'(cpu_rvalid), 64'd0);
      check("rstb_rdata",  64'(cpu_rdata),  64'd0);
      check("rstb_ack",    64'(cam_ack),    64'd0);
      check("rstb_cnt",    64'({dbg_starve, dbg_burst}), 64'd0);
      @(posedge clk); #1;

      // Camera re-requests after reset
      push_cam_wr(32'h900);
      push_cam_wr(32'h901);
      run(0, 0, 32'h0, 2, 32'h900, 1, 20);
      check("rerq_cycles", 64'(n_cyc), 64'd2);

      repeat (3) @(posedge clk);
      check("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
      check("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port synchronous data memory between the CPU MEM stage and the camera frame-capture DMA, which is write-only.
- The CPU has default priority. A starvation counter guarantees camera progress, and a burst counter bounds camera ownership.
- Drives the memory port, a stall to the pipeline control (holds the EXE/MEM and earlier registers while the CPU access is pending), and an accept strobe to the camera.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data width.
- CAM_BURST, 8, maximum camera words accepted per ownership period (>=1).
- STARVE_MAX, 4, consecutive CPU grants while cam_req is pending before the camera is forced in (>=1).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU memory access this cycle (load or store in MEM stage).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_stall  out  1  CPU request not granted this cycle; hold pipeline.
- cpu_rvalid  out  1  load data valid (registered).
- cpu_rdata  out  DATA_W  load data.
- cam_req  in  1  camera word pending.
- cam_addr  in  ADDR_W  camera write address.
- cam_wdata  in  DATA_W  camera pixel word.
- cam_last  in  1  current camera word ends the frame line.
- cam_ack  out  1  camera word accepted this cycle.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (port reset), sampled on posedge clk.
- Reset values:
  - state = S_CPU; starve_cnt = 0; burst_cnt = 0.
  - cpu_rvalid = 0; cpu_rdata = 0.
  - Combinational outputs follow from the state with inputs: cpu_stall = cpu_req, cam_ack = 0 only when no grant applies.
- Grant (combinational from state, counters and requests; exactly one or zero grant per cycle):
  - S_CPU:
    - grant_cam when cam_req and (!cpu_req or starve_cnt == STARVE_MAX).
    - Otherwise grant_cpu when cpu_req.
  - S_CAM:
    - grant_cam when cam_req.
    - Otherwise grant_cpu when cpu_req, which covers the exit cycle.
- Memory port:
  - grant_cpu: mem_en = 1, mem_we = cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
  - grant_cam: mem_en = 1, mem_we = 1, mem_addr = cam_addr, mem_wdata = cam_wdata.
  - No grant: mem_en = 0, mem_we = 0, address and data = 0.
- Handshake outputs:
  - cpu_stall = cpu_req & !grant_cpu.
  - cam_ack = grant_cam.
  - Requesters hold request and payload stable until granted or acked.
- Load return:
  - A load granted in cycle N gives cpu_rvalid = 1 in N+1, with cpu_rdata = mem_rdata registered from the memory output.
  - Otherwise cpu_rvalid = 0 and cpu_rdata = 0.
  - Stores never raise cpu_rvalid.
- Starvation counter:
  - In S_CPU, if grant_cpu and cam_req: starve_cnt++ (saturating at STARVE_MAX).
  - On any grant_cam, or when cam_req = 0: starve_cnt = 0.
- State transitions:
  - S_CPU -> S_CAM on grant_cam, unless cam_last = 1 or CAM_BURST = 1 (stay in S_CPU); burst_cnt = 1.
  - S_CAM, grant_cam: burst_cnt++. Return to S_CPU if cam_last or burst_cnt + 1 == CAM_BURST; burst_cnt = 0.
  - S_CAM, cam_req = 0: return to S_CPU immediately, and the CPU is granted that same cycle if requesting.
- Simultaneous events:
  - cpu_req and cam_req both high in S_CPU with starve_cnt < STARVE_MAX: CPU wins.
  - Once starve_cnt == STARVE_MAX, the camera wins.
- Reset mid-burst: the next cycle is S_CPU with counters cleared. Any in-flight cpu_rvalid is squashed to 0. Partial camera bursts are not resumed; the camera re-requests.

Test Plan:
- Reset, idle, then a CPU load to 0x40 where memory[0x40] = 0xDEADBEEF: cpu_stall = 0, mem_en = 1, mem_we = 0; next cycle cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF.
- Camera-only burst of 10 words (addresses 0x100..0x109), cam_last on the 10th, CAM_BURST = 8:
  - cam_ack for 8 consecutive cycles, then state returns to S_CPU.
  - Re-grant on the next cycle; all 10 words written in order.
- CPU and camera requesting continuously, STARVE_MAX = 4:
  - 4 CPU grants, then a camera burst (CPU stalled, cpu_stall = 1 for the burst length), then CPU again.
  - Pattern repeats; no requester is starved.
- Camera burst in progress while a CPU store arrives: cpu_stall = 1 until the burst ends on cam_last; the store is written in the first cycle after the burst.
- Camera drops cam_req mid-burst at word 3 with cpu_req high: the CPU is granted that same cycle; burst_cnt = 0 next cycle.
- Assert reset during a camera burst and the cycle after a CPU load grant: next cycle state = S_CPU, cpu_rvalid = 0, cam_ack = 0 while cam_req is low, counters = 0.
